text_overlay: RTL and testbench
===============================

Name: text_overlay

Overview:
- Character-cell text renderer: the reader side of the 8x8 font ROM.
- Holds a COLS x ROWS character buffer that the CPU writes.
- For each incoming HDMI pixel coordinate, it reads the character code, drives the font ROM address (ascii, row) and selects the bitmap bit.
- Emits a delay-matched RGB pixel with syncs.
- Sits between the HDMI timing generator and the TMDS encoder.

Parameters:
- COLS, 80, characters per line (8 px each)
- ROWS, 60, text lines (8 px each); COLS*ROWS ≤ 8192
- FG_COLOR, 24'hFFFFFF, RGB for a set glyph bit
- BG_COLOR, 24'h000000, RGB for a clear bit or outside the text area

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  CPU write strobe to the character buffer
- wr_addr  in  13  cell index = line*COLS + column
- wr_data  in  8  ASCII code
- clr_start  in  1  pulse: fill buffer with 8'h20
- busy  out  1  clear sweep in progress
- de_in, hs_in, vs_in  in  1 each  timing from the generator
- x_in, y_in  in  12 each  active-pixel coordinate (valid when de_in=1)
- font_ascii  out  8  to font ROM ascii_code
- font_row  out  3  to font ROM row
- font_data  in  8  font ROM row bitmap (combinational, same cycle)
- de_out, hs_out, vs_out  out  1 each  delayed timing
- rgb_out  out  24  pixel colour

Behaviour:
- Reset (the only reset is the synchronous active-high rst on clk):
  - All pipeline registers cleared; de_out/hs_out/vs_out=0, rgb_out=0, font_ascii=0, font_row=0.
  - FSM loads CLEAR with clr_ptr=0, so busy=1 out of reset.
  - Buffer RAM contents are not reset; the automatic clear covers them.
- FSM IDLE:
  - busy=0.
  - clr_start=1 -> CLEAR, clr_ptr=0.
  - wr_en with wr_addr < COLS*ROWS writes the buffer; out-of-range addresses are dropped silently.
- FSM CLEAR:
  - Each cycle writes 8'h20 at clr_ptr, then clr_ptr++.
  - After writing COLS*ROWS-1 -> IDLE; busy drops the following cycle.
  - Sweep takes exactly COLS*ROWS cycles.
  - wr_en and clr_start are ignored while busy.
  - rst mid-sweep restarts the sweep at 0.
- Buffer: single write port (CPU or clear) and one synchronous read port (pixel path). On a same-cycle read and write to the same address, the read returns the old data.
- Pixel pipeline, fixed latency of 3 cycles from *_in to *_out, active regardless of FSM state:
  - S1: register inside = de_in && x_in < COLS*8 && y_in < ROWS*8; cell = (y_in>>3)*COLS + (x_in>>3); x_in[2:0]; y_in[2:0]; syncs.
  - S2: buffer read of cell -> char register; pass on the sub-coordinates, inside flag and syncs.
  - S3: font_ascii=char and font_row=ysub, driven from S2 registers; pix = font_data[7-xsub]; register rgb_out = (inside & pix) ? FG_COLOR : BG_COLOR; de_out/hs_out/vs_out register the S2 copies.
- When de_out=0, rgb_out=0.
- Characters the ROM does not cover return 8'h00 and render as BG.
- The multiply by COLS is constant (synthesised as shift/add); address width is 13 bits with no wrap.

Decomposition:
- Shared package (text_pkg):
  - CHAR_W=8, CHAR_H=8
  - ADDR_W=13
  - SPACE_CODE=8'h20
  - FSM state encoding {IDLE, CLEAR}
- One natural sub-module: text_buffer_ram (simple dual-port, 1 write / 1 synchronous read, depth COLS*ROWS, 8-bit).
- font_rom is instantiated alongside this block at the top level, not inside it.

Test Plan:
- Reset 3 cycles, release -> busy=1 for exactly 4800 cycles (80x60), then 0; full-frame scan gives rgb_out=BG on every de_out pixel.
- Write wr_addr=0, wr_data=8'h31 ('1'); scan x=0..7, y=2 -> de_in at cycle t gives rgb_out at t+3 = BG,BG,FG,FG,BG,BG,BG,BG (row 8'b00110000).
- Write wr_addr=81 ('0' at line 1, column 1); pixel x=8, y=11 -> FG (row 3 = 8'b11011000, bit7); x=10, y=11 -> BG.
- Pixel x=640 or y=480 with de_in=1 -> BG; wr_addr=4800 write is ignored and cell 0 is unchanged.
- Pulse clr_start after writes -> busy for 4800 cycles; wr_en during the sweep is dropped; after the sweep all cells read 8'h20; a second clr_start mid-sweep has no effect.
- Assert rst for 1 cycle in the middle of CLEAR -> outputs 0 that cycle, sweep restarts at 0 and busy lasts a full 4800 cycles; hs_in/vs_in patterns reappear on hs_out/vs_out exactly 3 cycles later.

Source files
------------

// File: rtl/text_overlay_pkg.sv
// ==== text_pkg ================================================================
// Shared constants, state encoding and helpers for the text overlay. Rev 1.0
// ==============================================================================
`default_nettype none

package text_pkg;

  localparam int CHAR_W  = 8;
  localparam int CHAR_H  = 8;
  localparam int ADDR_W  = 13;
  localparam int COORD_W = 12;
  localparam int RGB_W   = 24;

  localparam logic [7:0] SPACE_CODE = 8'h20;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  // Row-major cell index; the multiply is by a constant so it folds to shift/add.
  function automatic logic [ADDR_W-1:0] cell_index(
    input logic [COORD_W-4:0] line,
    input logic [COORD_W-4:0] col,
    input int                 cols
  );
    return ADDR_W'(line) * ADDR_W'(cols) + ADDR_W'(col);
  endfunction

endpackage

`default_nettype wire

// File: rtl/text_overlay_if.sv
// ==== text_overlay_if =========================================================
// CPU buffer port, video timing in/out and font ROM link of the overlay. Rev 1.0
// ==============================================================================
`default_nettype none

interface text_overlay_if;
  import text_pkg::*;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [7:0]          wr_data;
  logic                clr_start;
  logic                busy;

  logic                de_in;
  logic                hs_in;
  logic                vs_in;
  logic [COORD_W-1:0]  x_in;
  logic [COORD_W-1:0]  y_in;

  logic [7:0]          font_ascii;
  logic [2:0]          font_row;
  logic [7:0]          font_data;

  logic                de_out;
  logic                hs_out;
  logic                vs_out;
  logic [RGB_W-1:0]    rgb_out;

  modport master (
    output wr_en, wr_addr, wr_data, clr_start,
    output de_in, hs_in, vs_in, x_in, y_in,
    output font_data,
    input  busy, font_ascii, font_row,
    input  de_out, hs_out, vs_out, rgb_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clr_start,
    input  de_in, hs_in, vs_in, x_in, y_in,
    input  font_data,
    output busy, font_ascii, font_row,
    output de_out, hs_out, vs_out, rgb_out
  );

endinterface

`default_nettype wire

// File: rtl/text_overlay_buffer_ram.sv
// ==== text_buffer_ram =========================================================
// Character buffer: one write port, one registered read port (old-data). Rev 1.0
// ==============================================================================
`default_nettype none

module text_buffer_ram
  import text_pkg::*;
#(
  parameter int DEPTH  = 4800,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read register is part of the pixel pipeline, so it resets; the array does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/text_overlay.sv
// ==== text_overlay ============================================================
// Character-cell text renderer: buffer, clear sweep, 3-stage pixel path. Rev 1.0
// ==============================================================================
`default_nettype none

module text_overlay
  import text_pkg::*;
#(
  parameter int               COLS     = 80,
  parameter int               ROWS     = 60,
  parameter logic [RGB_W-1:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [RGB_W-1:0] BG_COLOR = 24'h000000
) (
  input  logic          clk,
  input  logic          rst,
  text_overlay_if.slave bus
);

  localparam int                 DEPTH   = COLS * ROWS;
  localparam logic [ADDR_W-1:0]  C_DEPTH = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0]  C_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [COORD_W-1:0] C_X_LIM = COORD_W'(COLS * CHAR_W);
  localparam logic [COORD_W-1:0] C_Y_LIM = COORD_W'(ROWS * CHAR_H);

  // ---------------------------------------------------------------- clear FSM
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.clr_start) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_clr_ptr == C_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_busy   = (r_state == ST_CLEAR);
  assign bus.busy = w_busy;

  // ------------------------------------------------------- buffer write mux
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [7:0]        w_wdata;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = bus.wr_addr;
    w_wdata = bus.wr_data;
    if (!rst) begin
      if (w_busy) begin
        w_we    = 1'b1;
        w_waddr = r_clr_ptr;
        w_wdata = SPACE_CODE;
      end else if (bus.wr_en && (bus.wr_addr < C_DEPTH)) begin
        w_we = 1'b1;
      end
    end
  end

  // ------------------------------------------------------- S1: address calc
  logic              w_inside;
  logic [ADDR_W-1:0] w_cell;

  logic              r_s1_inside;
  logic [ADDR_W-1:0] r_s1_cell;
  logic [2:0]        r_s1_xsub;
  logic [2:0]        r_s1_ysub;
  sync_t             r_s1_sync;

  assign w_inside = bus.de_in && (bus.x_in < C_X_LIM) && (bus.y_in < C_Y_LIM);
  // Outside pixels read cell 0 so the RAM is never addressed beyond its depth.
  assign w_cell   = w_inside ? cell_index(bus.y_in[COORD_W-1:3], bus.x_in[COORD_W-1:3], COLS)
                             : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_inside <= 1'b0;
      r_s1_cell   <= '0;
      r_s1_xsub   <= '0;
      r_s1_ysub   <= '0;
      r_s1_sync   <= '0;
    end else begin
      r_s1_inside <= w_inside;
      r_s1_cell   <= w_cell;
      r_s1_xsub   <= bus.x_in[2:0];
      r_s1_ysub   <= bus.y_in[2:0];
      r_s1_sync   <= '{de: bus.de_in, hs: bus.hs_in, vs: bus.vs_in};
    end
  end

  // ------------------------------------------------------- S2: buffer read
  logic [7:0] w_char;
  logic       r_s2_inside;
  logic [2:0] r_s2_xsub;
  logic [2:0] r_s2_ysub;
  sync_t      r_s2_sync;

  text_buffer_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (8)
  ) u_buffer (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .raddr (r_s1_cell),
    .rdata (w_char)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_inside <= 1'b0;
      r_s2_xsub   <= '0;
      r_s2_ysub   <= '0;
      r_s2_sync   <= '0;
    end else begin
      r_s2_inside <= r_s1_inside;
      r_s2_xsub   <= r_s1_xsub;
      r_s2_ysub   <= r_s1_ysub;
      r_s2_sync   <= r_s1_sync;
    end
  end

  // ------------------------------------------------ S3: font lookup, colour
  logic             w_pix;
  logic [RGB_W-1:0] r_rgb;
  sync_t            r_out_sync;

  assign bus.font_ascii = w_char;
  assign bus.font_row   = r_s2_ysub;
  // Bit 7 of a font row is the leftmost pixel of the cell.
  assign w_pix          = bus.font_data[3'd7 - r_s2_xsub];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb      <= '0;
      r_out_sync <= '0;
    end else begin
      r_out_sync <= r_s2_sync;
      if (!r_s2_sync.de) begin
        r_rgb <= '0;
      end else if (r_s2_inside && w_pix) begin
        r_rgb <= FG_COLOR;
      end else begin
        r_rgb <= BG_COLOR;
      end
    end
  end

  assign bus.de_out  = r_out_sync.de;
  assign bus.hs_out  = r_out_sync.hs;
  assign bus.vs_out  = r_out_sync.vs;
  assign bus.rgb_out = r_rgb;

endmodule

`default_nettype wire

// File: tb/tb_text_overlay.sv
// ==== tb_text_overlay =========================================================
// Self-checking bench for text_overlay against a cell/glyph reference model. Rev 1.0
// ==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_text_overlay;
  import text_pkg::*;

  localparam int          COLS  = 80;
  localparam int          ROWS  = 60;
  localparam int          DEPTH = COLS * ROWS;
  localparam logic [23:0] FG    = 24'hF0A501;
  localparam logic [23:0] BG    = 24'h102030;

  typedef struct {
    int x;
    int y;
    bit de;
    bit hs;
    bit vs;
  } pix_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] font_tbl [0:2047];
  int         model_buf [DEPTH];

  text_overlay_if bus();

  always #5 clk = ~clk;

  assign bus.font_data = font_tbl[{bus.font_ascii, bus.font_row}];

  text_overlay #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .FG_COLOR (FG),
    .BG_COLOR (BG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int x, input int y, input bit de, input bit hs, input bit vs);
    bus.x_in  = 12'(x);
    bus.y_in  = 12'(y);
    bus.de_in = de;
    bus.hs_in = hs;
    bus.vs_in = vs;
  endtask

  task automatic cpu_write(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 13'(addr);
    bus.wr_data = 8'(data);
    tick();
    bus.wr_en   = 1'b0;
    if (addr < DEPTH) model_buf[addr] = data;
  endtask

  function automatic bit in_text(input int x, input int y);
    return (x < COLS * CHAR_W) && (y < ROWS * CHAR_H);
  endfunction

  // Reference pixel: glyph bit of the stored character, leftmost pixel = bit 7.
  function automatic logic [23:0] exp_rgb(input int x, input int y, input bit de);
    int         ch;
    logic [7:0] bits;
    if (!de) return 24'h0;
    if (!in_text(x, y)) return BG;
    ch   = model_buf[(y / CHAR_H) * COLS + x / CHAR_W];
    bits = font_tbl[ch * 8 + y % 8];
    return bits[7 - x % 8] ? FG : BG;
  endfunction

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_pix($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'(i), 1'(i + 1));
      tick();
      total++;
      if ({bus.de_out, bus.hs_out, bus.vs_out, bus.rgb_out, bus.font_ascii, bus.font_row, bus.busy} !== {38'h0, 1'b1}) begin
        bad++;
        $display("FAIL reset_outputs[%0d] got de=%b hs=%b vs=%b rgb=%h asc=%h row=%0d busy=%b exp zeros busy=1",
                 i, bus.de_out, bus.hs_out, bus.vs_out, bus.rgb_out, bus.font_ascii, bus.font_row, bus.busy);
      end
    end
    set_pix(0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 6000) begin
      cnt++;
      tick();
    end
    total++;
    if (cnt !== DEPTH) begin
      bad++;
      $display("FAIL reset_busy_len got=%0d exp=%0d", cnt, DEPTH);
    end
    for (int c = 0; c < DEPTH; c++) model_buf[c] = 32'h20;
  endtask

  // Touches every cell once at a random sub-pixel, then random off-text and blanked pixels.
  task automatic test_frame_scan(input string tag);
    pix_t        q[$];
    pix_t        p;
    logic [26:0] exp_v;
    logic [26:0] got_v;
    for (int c = 0; c < DEPTH; c++) begin
      p.x  = (c % COLS) * CHAR_W + int'($urandom_range(0, 7));
      p.y  = (c / COLS) * CHAR_H + int'($urandom_range(0, 7));
      p.de = 1'b1;
      p.hs = 1'($urandom);
      p.vs = 1'($urandom);
      q.push_back(p);
    end
    for (int k = 0; k < 120; k++) begin
      p.x  = (k % 2 == 0) ? int'($urandom_range(640, 4095)) : int'($urandom_range(0, 4095));
      p.y  = (k % 2 == 1) ? int'($urandom_range(480, 4095)) : int'($urandom_range(0, 4095));
      p.de = (k % 3 != 0);
      p.hs = 1'($urandom);
      p.vs = 1'($urandom);
      q.push_back(p);
    end
    for (int i = 0; i < q.size() + 2; i++) begin
      if (i < q.size()) set_pix(q[i].x, q[i].y, q[i].de, q[i].hs, q[i].vs);
      else              set_pix(0, 0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i >= 1 && i - 1 < q.size()) begin
        p = q[i - 1];
        total++;
        if (bus.font_row !== 3'(p.y % 8)) begin
          bad++;
          $display("FAIL %s_font_row[%0d] got=%0d exp=%0d", tag, i - 1, bus.font_row, p.y % 8);
        end
        if (p.de && in_text(p.x, p.y)) begin
          total++;
          if (bus.font_ascii !== 8'(model_buf[(p.y / 8) * COLS + p.x / 8])) begin
            bad++;
            $display("FAIL %s_font_ascii[%0d] x=%0d y=%0d got=%h exp=%h", tag, i - 1, p.x, p.y,
                     bus.font_ascii, 8'(model_buf[(p.y / 8) * COLS + p.x / 8]));
          end
        end
      end
      if (i >= 2) begin
        p     = q[i - 2];
        exp_v = {p.de, p.hs, p.vs, exp_rgb(p.x, p.y, p.de)};
        got_v = {bus.de_out, bus.hs_out, bus.vs_out, bus.rgb_out};
        total++;
        if (got_v !== exp_v) begin
          bad++;
          $display("FAIL %s_pixel[%0d] x=%0d y=%0d got=%h exp=%h", tag, i - 2, p.x, p.y, got_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_glyph_one();
    logic [7:0]  pat = 8'b00110000;
    logic [23:0] exp_c;
    cpu_write(0, 8'h31);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_pix(i, 2, 1'b1, 1'b0, 1'b0);
      else       set_pix(0, 0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i >= 2) begin
        exp_c = pat[7 - (i - 2)] ? FG : BG;
        total++;
        if ({bus.de_out, bus.rgb_out} !== {1'b1, exp_c}) begin
          bad++;
          $display("FAIL glyph_one[x=%0d] got de=%b rgb=%h exp de=1 rgb=%h", i - 2, bus.de_out, bus.rgb_out, exp_c);
        end
      end
    end
  endtask

  task automatic test_glyph_zero();
    int          xs[2]  = '{8, 10};
    logic [23:0] exps[2] = '{FG, BG};
    cpu_write(81, 8'h30);
    for (int i = 0; i < 4; i++) begin
      if (i < 2) set_pix(xs[i], 11, 1'b1, 1'b0, 1'b0);
      else       set_pix(0, 0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i >= 2) begin
        total++;
        if (bus.rgb_out !== exps[i - 2]) begin
          bad++;
          $display("FAIL glyph_zero[x=%0d] got=%h exp=%h", xs[i - 2], bus.rgb_out, exps[i - 2]);
        end
      end
    end
  endtask

  task automatic test_bounds();
    pix_t        q[5];
    logic [25:0] exps[5];
    cpu_write(4800, 8'h00);
    cpu_write(8191, 8'h00);
    q[0] = '{640, 0, 1'b1, 1'b1, 1'b0};
    q[1] = '{0, 480, 1'b1, 1'b0, 1'b1};
    q[2] = '{5, 2, 1'b0, 1'b1, 1'b1};
    q[3] = '{2, 2, 1'b1, 1'b0, 1'b0};
    q[4] = '{639, 479, 1'b1, 1'b0, 1'b0};
    exps[0] = {1'b1, 1'b1, BG};
    exps[1] = {1'b1, 1'b0, BG};
    exps[2] = {1'b0, 1'b1, 24'h0};
    exps[3] = {1'b1, 1'b0, FG};
    exps[4] = {1'b1, 1'b0, BG};
    for (int i = 0; i < 7; i++) begin
      if (i < 5) set_pix(q[i].x, q[i].y, q[i].de, q[i].hs, q[i].vs);
      else       set_pix(0, 0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i >= 2) begin
        total++;
        if ({bus.de_out, bus.hs_out, bus.rgb_out} !== exps[i - 2]) begin
          bad++;
          $display("FAIL bounds[%0d] got=%h exp=%h", i - 2, {bus.de_out, bus.hs_out, bus.rgb_out}, exps[i - 2]);
        end
      end
    end
  endtask

  task automatic test_random_writes();
    for (int k = 0; k < 300; k++) begin
      if (k % 10 == 0) cpu_write(int'($urandom_range(DEPTH, 8191)), int'($urandom_range(0, 255)));
      else             cpu_write(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)));
    end
    test_frame_scan("rand");
  endtask

  task automatic test_clear();
    int cnt;
    set_pix(0, 0, 1'b0, 1'b0, 1'b0);
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 6000) begin
      cnt++;
      bus.clr_start = (cnt == 2000);
      bus.wr_en     = ($urandom_range(0, 3) == 0);
      bus.wr_addr   = 13'($urandom_range(0, DEPTH - 1));
      bus.wr_data   = 8'($urandom_range(0, 255));
      tick();
    end
    bus.wr_en     = 1'b0;
    bus.clr_start = 1'b0;
    total++;
    if (cnt !== DEPTH) begin
      bad++;
      $display("FAIL clear_busy_len got=%0d exp=%0d", cnt, DEPTH);
    end
    for (int c = 0; c < DEPTH; c++) model_buf[c] = 32'h20;
    test_frame_scan("clear");
  endtask

  task automatic test_reset_mid_clear();
    int       cnt;
    bit [1:0] hist[$];
    bit [1:0] sv;
    cpu_write(0, 8'h31);
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      set_pix(0, 0, 1'b0, 1'($urandom), 1'($urandom));
      tick();
    end
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL midclear_busy got=%b exp=1", bus.busy);
    end
    rst = 1'b1;
    set_pix(3, 2, 1'b1, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    total++;
    if ({bus.de_out, bus.hs_out, bus.vs_out, bus.rgb_out, bus.font_ascii, bus.font_row, bus.busy} !== {38'h0, 1'b1}) begin
      bad++;
      $display("FAIL midclear_rst_outputs got de=%b hs=%b vs=%b rgb=%h asc=%h row=%0d busy=%b exp zeros busy=1",
               bus.de_out, bus.hs_out, bus.vs_out, bus.rgb_out, bus.font_ascii, bus.font_row, bus.busy);
    end
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 6000) begin
      sv = 2'($urandom);
      set_pix(0, 0, 1'b0, sv[1], sv[0]);
      hist.push_back(sv);
      cnt++;
      tick();
      if (cnt >= 3) begin
        total++;
        if ({bus.hs_out, bus.vs_out, bus.de_out, bus.rgb_out} !== {hist[cnt - 3], 25'h0}) begin
          bad++;
          $display("FAIL midclear_sync[%0d] got hs=%b vs=%b de=%b rgb=%h exp hs=%b vs=%b de=0 rgb=0",
                   cnt - 3, bus.hs_out, bus.vs_out, bus.de_out, bus.rgb_out, hist[cnt - 3][1], hist[cnt - 3][0]);
        end
      end
    end
    total++;
    if (cnt !== DEPTH) begin
      bad++;
      $display("FAIL midclear_busy_len got=%0d exp=%0d", cnt, DEPTH);
    end
    for (int c = 0; c < DEPTH; c++) model_buf[c] = 32'h20;
    test_frame_scan("midclear");
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) font_tbl[a] = (a < 128 * 8) ? 8'($urandom) : 8'h00;
    for (int r = 0; r < 8; r++) begin
      font_tbl[32 * 8 + r] = 8'h00;
      font_tbl[r]          = 8'h00;
    end
    font_tbl[8'h31 * 8 + 2] = 8'b00110000;
    font_tbl[8'h30 * 8 + 3] = 8'b11011000;

    rst           = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.clr_start = 1'b0;
    set_pix(0, 0, 1'b0, 1'b0, 1'b0);

    test_reset();
    test_frame_scan("blank");
    test_glyph_one();
    test_glyph_zero();
    test_bounds();
    test_random_writes();
    test_clear();
    test_reset_mid_clear();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
